// File: rtl/latch_bus_pkg.sv
// Shared types and constants for the octal-latch bus scheduler.
package latch_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_OE,
        ST_SAMPLE,
        ST_TURN
    } state_e;

    localparam int PHASE_W = 4;

    // Phase counter counts down to zero, so a state lasting N cycles loads N-1.
    function automatic logic [PHASE_W-1:0] phase_load(input int cycles);
        return PHASE_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the index after the last accepted grant.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req_i,
    input  logic             accept_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_any_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    always_comb begin
        int               idx;
        logic [IDX_W-1:0] cand;
        logic             found;
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = IDX_W'(idx);
            if (!found && req_i[cand]) begin
                found      = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o  = cand;
            end
        end
        gnt_any_o = found;
    end

    assign ptr_d = (gnt_idx_o == IDX_W'(NREQ - 1)) ? '0 : gnt_idx_o + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (accept_i && gnt_any_o) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/latch_bus_sched.sv
// Schedules write strobes and output-enable reads to octal latches sharing
// one 8-bit bus, with a turnaround cycle after every read.
module latch_bus_sched
    import latch_bus_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int NLATCH   = 4,
    parameter int T_SETUP  = 1,
    parameter int T_STROBE = 2,
    parameter int T_HOLD   = 1,
    parameter int T_OE     = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ-1:0]               req_wr,
    input  logic [NREQ*$clog2(NLATCH)-1:0] req_sel,
    input  logic [NREQ*8-1:0]             req_data,
    output logic [NREQ-1:0]               req_ready,
    output logic [NLATCH-1:0]             lat_c,
    output logic [NLATCH-1:0]             lat_ocn,
    output logic [7:0]                    bus_dout,
    output logic                          bus_drive,
    input  logic [7:0]                    bus_din,
    output logic                          rsp_valid,
    output logic [$clog2(NREQ)-1:0]       rsp_id,
    output logic [7:0]                    rsp_data
);

    localparam int SEL_W = $clog2(NLATCH);
    localparam int ID_W  = $clog2(NREQ);

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [7:0]         data_q, data_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [7:0]         rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;

    logic [NREQ-1:0]    gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic               accept;
    logic [NLATCH-1:0]  sel_oh;

    // Held off during reset so no acceptance pulse escapes while reset is high.
    assign accept = (state_q == ST_IDLE) && gnt_any && !reset;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (ID_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_valid),
        .accept_i  (accept),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    // Out-of-range selects decode to no latch at all.
    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < NLATCH; i++) begin
            sel_oh[i] = (sel_q == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            sel_q      <= '0;
            data_q     <= '0;
            id_q       <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
            id_q       <= id_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = (phase_q != '0) ? phase_q - 1'b1 : phase_q;
        sel_d      = sel_q;
        data_d     = data_q;
        id_d       = id_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sel_d  = req_sel[int'(gnt_idx)*SEL_W +: SEL_W];
                    data_d = req_data[int'(gnt_idx)*8 +: 8];
                    id_d   = gnt_idx;
                    if (req_wr[gnt_idx]) begin
                        state_d = ST_SETUP;
                        phase_d = phase_load(T_SETUP);
                    end else begin
                        state_d = ST_OE;
                        phase_d = phase_load(T_OE);
                    end
                end
            end
            ST_SETUP: begin
                if (phase_q == '0) begin
                    state_d = ST_STROBE;
                    phase_d = phase_load(T_STROBE);
                end
            end
            ST_STROBE: begin
                if (phase_q == '0) begin
                    state_d = ST_HOLD;
                    phase_d = phase_load(T_HOLD);
                end
            end
            ST_HOLD: begin
                if (phase_q == '0) state_d = ST_IDLE;
            end
            ST_OE: begin
                // Bus is captured on the edge into SAMPLE and presented there.
                if (phase_q == '0) begin
                    state_d    = ST_SAMPLE;
                    rsp_data_d = (|sel_oh) ? bus_din : 8'hFF;
                    rsp_id_d   = id_q;
                end
            end
            ST_SAMPLE: state_d = ST_TURN;
            ST_TURN:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = accept ? gnt : '0;
        lat_c     = '0;
        lat_ocn   = '1;
        bus_drive = 1'b0;
        bus_dout  = '0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_SETUP, ST_HOLD: begin
                bus_drive = 1'b1;
                bus_dout  = data_q;
            end
            ST_STROBE: begin
                bus_drive = 1'b1;
                bus_dout  = data_q;
                lat_c     = sel_oh;
            end
            ST_OE: lat_ocn = ~sel_oh;
            ST_SAMPLE: begin
                lat_ocn   = ~sel_oh;
                rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign rsp_data = rsp_data_q;
    assign rsp_id   = rsp_id_q;

endmodule

// File: tb/tb_latch_bus_sched.sv
// Directed bench for latch_bus_sched with a behavioural octal-latch bus model.
module tb_latch_bus_sched;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid, req_wr, req_ready;
    logic [7:0]  req_sel;
    logic [31:0] req_data;
    logic [3:0]  lat_c, lat_ocn;
    logic [7:0]  bus_dout, bus_din, rsp_data;
    logic        bus_drive, rsp_valid;
    logic [1:0]  rsp_id;

    logic [3:0]  v3, wr3, ready3;
    logic [7:0]  sel3, dout3, din3, rspd3;
    logic [31:0] data3;
    logic [2:0]  lat_c3, lat_ocn3;
    logic        drive3, rspv3;
    logic [1:0]  rspid3;

    logic [7:0]  mem [4];
    logic        use_ovr;
    logic [7:0]  din_ovr;

    int checks = 0;
    int errors = 0;

    latch_bus_sched u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_wr(req_wr),
        .req_sel(req_sel), .req_data(req_data), .req_ready(req_ready),
        .lat_c(lat_c), .lat_ocn(lat_ocn), .bus_dout(bus_dout), .bus_drive(bus_drive),
        .bus_din(bus_din), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    latch_bus_sched #(.NLATCH(3)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(v3), .req_wr(wr3),
        .req_sel(sel3), .req_data(data3), .req_ready(ready3),
        .lat_c(lat_c3), .lat_ocn(lat_ocn3), .bus_dout(dout3), .bus_drive(drive3),
        .bus_din(din3), .rsp_valid(rspv3), .rsp_id(rspid3), .rsp_data(rspd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Latch model: captures while C is high, drives the bus while OC_n is low.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) if (lat_c[i]) mem[i] <= bus_dout;
    end

    always_comb begin
        bus_din = 8'hFF;
        for (int i = 0; i < 4; i++) if (!lat_ocn[i]) bus_din = mem[i];
        if (use_ovr) bus_din = din_ovr;
    end

    task automatic set_req(input int r, input logic wr, input logic [1:0] sel, input logic [7:0] d);
        req_wr[r]         = wr;
        req_sel[r*2 +: 2] = sel;
        req_data[r*8 +: 8] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 4'hF;
        req_wr = 4'hF;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready: got %h want 0", req_ready); end
        checks++; if (lat_c !== 4'h0) begin errors++; $display("FAIL reset_lat_c: got %h want 0", lat_c); end
        checks++; if (lat_ocn !== 4'hF) begin errors++; $display("FAIL reset_lat_ocn: got %h want f", lat_ocn); end
        checks++; if (bus_drive !== 1'b0) begin errors++; $display("FAIL reset_bus_drive: got %b want 0", bus_drive); end
        checks++; if (bus_dout !== 8'h00) begin errors++; $display("FAIL reset_bus_dout: got %h want 00", bus_dout); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data); end
        checks++; if (lat_ocn3 !== 3'b111) begin errors++; $display("FAIL reset_lat_ocn3: got %b want 111", lat_ocn3); end
        reset = 1'b0;
        req_valid = 4'h0;
        @(negedge clk);
    endtask

    // Write A5 to latch 2: SETUP(1) STROBE(2) HOLD(1) then IDLE.
    task automatic test_write();
        logic [3:0] exp_c;
        logic       exp_drv;
        logic [7:0] exp_dout;
        @(negedge clk);
        set_req(0, 1'b1, 2'd2, 8'hA5);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wr_ready: got %b want 0001", req_ready); end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            req_valid = 4'h0;
            #1;
            exp_c    = (k == 2 || k == 3) ? 4'b0100 : 4'b0000;
            exp_drv  = (k <= 4);
            exp_dout = (k <= 4) ? 8'hA5 : 8'h00;
            checks++; if (lat_c !== exp_c) begin errors++; $display("FAIL wr_lat_c[%0d]: got %b want %b", k, lat_c, exp_c); end
            checks++; if (bus_drive !== exp_drv) begin errors++; $display("FAIL wr_drive[%0d]: got %b want %b", k, bus_drive, exp_drv); end
            checks++; if (bus_dout !== exp_dout) begin errors++; $display("FAIL wr_dout[%0d]: got %h want %h", k, bus_dout, exp_dout); end
            checks++; if (lat_ocn !== 4'hF) begin errors++; $display("FAIL wr_ocn[%0d]: got %b want 1111", k, lat_ocn); end
        end
        checks++; if (mem[2] !== 8'hA5) begin errors++; $display("FAIL wr_latched: got %h want a5", mem[2]); end
    endtask

    // Read latch 1 with the bus held at 3C: OE(2) SAMPLE TURN.
    task automatic test_read();
        logic [3:0] exp_ocn;
        logic       exp_rv;
        @(negedge clk);
        use_ovr = 1'b1;
        din_ovr = 8'h3C;
        set_req(1, 1'b0, 2'd1, 8'h00);
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rd_ready: got %b want 0010", req_ready); end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            req_valid = 4'h0;
            #1;
            exp_ocn = (k <= 3) ? 4'b1101 : 4'b1111;
            exp_rv  = (k == 3);
            checks++; if (lat_ocn !== exp_ocn) begin errors++; $display("FAIL rd_ocn[%0d]: got %b want %b", k, lat_ocn, exp_ocn); end
            checks++; if (rsp_valid !== exp_rv) begin errors++; $display("FAIL rd_rsp_valid[%0d]: got %b want %b", k, rsp_valid, exp_rv); end
            checks++; if (bus_drive !== 1'b0) begin errors++; $display("FAIL rd_drive[%0d]: got %b want 0", k, bus_drive); end
            if (k == 3) begin
                checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL rd_rsp_id: got %0d want 1", rsp_id); end
                checks++; if (rsp_data !== 8'h3C) begin errors++; $display("FAIL rd_rsp_data: got %h want 3c", rsp_data); end
            end
        end
        use_ovr = 1'b0;
    endtask

    // Requester 2 held valid alone: re-granted on the first IDLE cycle each time.
    task automatic test_back_to_back();
        int t[3];
        int n;
        int drv;
        n = 0;
        drv = 0;
        @(negedge clk);
        set_req(2, 1'b1, 2'd0, 8'h77);
        req_valid = 4'b0100;
        for (int cyc = 0; cyc <= 12; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (bus_drive === 1'b1 && n == 1) drv++;
            if (req_ready !== 4'h0) begin
                checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL b2b_onehot: got %b want 0100", req_ready); end
                if (n < 3) t[n] = cyc;
                n++;
            end
        end
        req_valid = 4'h0;
        checks++; if (n != 3) begin errors++; $display("FAIL b2b_grants: got %0d want 3", n); end
        else begin
            checks++; if (t[1] - t[0] != 5) begin errors++; $display("FAIL b2b_gap1: got %0d want 5", t[1] - t[0]); end
            checks++; if (t[2] - t[1] != 5) begin errors++; $display("FAIL b2b_gap2: got %0d want 5", t[2] - t[1]); end
        end
        checks++; if (drv != 4) begin errors++; $display("FAIL b2b_drive_cycles: got %0d want 4", drv); end
        repeat (6) @(negedge clk);
    endtask

    // All four requesting continuously from a reset pointer.
    task automatic test_contention();
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        int seq[5];
        int n;
        int last;
        n = 0;
        last = -1;
        do_reset();
        set_req(0, 1'b1, 2'd0, 8'h11);
        set_req(1, 1'b0, 2'd1, 8'h00);
        set_req(2, 1'b1, 2'd2, 8'h22);
        set_req(3, 1'b0, 2'd3, 8'h00);
        req_valid = 4'hF;
        for (int cyc = 0; cyc < 60 && n < 5; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            checks++; if (bus_drive === 1'b1 && lat_ocn !== 4'hF) begin errors++; $display("FAIL cont_overlap: drive %b ocn %b want no overlap", bus_drive, lat_ocn); end
            checks++; if ($countones(~lat_ocn) > 1) begin errors++; $display("FAIL cont_ocn_multi: got %b want at most one low", lat_ocn); end
            checks++; if ($countones(lat_c) > 1) begin errors++; $display("FAIL cont_c_multi: got %b want at most one high", lat_c); end
            if (rsp_valid === 1'b1) begin
                checks++; if (int'(rsp_id) != last) begin errors++; $display("FAIL cont_rsp_id: got %0d want %0d", rsp_id, last); end
            end
            if (req_ready !== 4'h0) begin
                checks++; if (!$onehot(req_ready)) begin errors++; $display("FAIL cont_onehot: got %b want one-hot", req_ready); end
                for (int i = 0; i < 4; i++) if (req_ready[i]) last = i;
                seq[n] = last;
                n++;
            end
        end
        req_valid = 4'h0;
        checks++; if (n != 5) begin errors++; $display("FAIL cont_timeout: got %0d grants want 5", n); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (seq[i] != exp_seq[i]) begin errors++; $display("FAIL cont_order[%0d]: got %0d want %0d", i, seq[i], exp_seq[i]); end
            end
        end
        repeat (8) @(negedge clk);
    endtask

    // A request raised and dropped while busy must not be served later.
    task automatic test_drop();
        @(negedge clk);
        set_req(0, 1'b1, 2'd0, 8'h33);
        set_req(3, 1'b1, 2'd1, 8'h44);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL drop_first: got %b want 0001", req_ready); end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            req_valid = (k <= 2) ? 4'b1000 : 4'b0000;
            #1;
            checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL drop_ready[%0d]: got %b want 0000", k, req_ready); end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_req(1, 1'b1, 2'd1, 8'h99);
        req_valid = 4'b0010;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (lat_c !== 4'b0010) begin errors++; $display("FAIL rstmid_strobe: got %b want 0010", lat_c); end
        #1;
        reset = 1'b1;
        #1;
        checks++; if (lat_c !== 4'h0) begin errors++; $display("FAIL rstmid_lat_c: got %b want 0000", lat_c); end
        checks++; if (bus_drive !== 1'b0) begin errors++; $display("FAIL rstmid_drive: got %b want 0", bus_drive); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL rstmid_ready[%0d]: got %b want 0000", k, req_ready); end
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rstmid_release: got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'h0;
        repeat (5) @(negedge clk);
        // Aborted read must produce no response.
        set_req(2, 1'b0, 2'd2, 8'h00);
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = 4'h0;
        #2;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_rsp[%0d]: got %b want 0", k, rsp_valid); end
            @(negedge clk);
        end
    endtask

    // Three-latch instance: select 3 does not exist.
    task automatic test_oor();
        @(negedge clk);
        din3 = 8'h00;
        wr3 = 4'b0000;
        sel3 = 8'b0000_0011;
        v3 = 4'b0001;
        #1;
        checks++; if (ready3 !== 4'b0001) begin errors++; $display("FAIL oor_ready: got %b want 0001", ready3); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            v3 = 4'h0;
            #1;
            checks++; if (lat_ocn3 !== 3'b111) begin errors++; $display("FAIL oor_ocn[%0d]: got %b want 111", k, lat_ocn3); end
            checks++; if (rspv3 !== (k == 3)) begin errors++; $display("FAIL oor_rsp_valid[%0d]: got %b want %b", k, rspv3, k == 3); end
            if (k == 3) begin
                checks++; if (rspd3 !== 8'hFF) begin errors++; $display("FAIL oor_rsp_data: got %h want ff", rspd3); end
            end
        end
        @(negedge clk);
        wr3 = 4'b0001;
        v3 = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            v3 = 4'h0;
            #1;
            checks++; if (lat_c3 !== 3'b000) begin errors++; $display("FAIL oor_lat_c[%0d]: got %b want 000", k, lat_c3); end
        end
    endtask

    task automatic test_wr_rd();
        logic       got;
        logic [7:0] rd;
        logic [1:0] id;
        got = 1'b0;
        rd = 8'h00;
        id = 2'd3;
        @(negedge clk);
        set_req(2, 1'b1, 2'd3, 8'h5A);
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = 4'h0;
        repeat (5) @(negedge clk);
        set_req(0, 1'b0, 2'd3, 8'h00);
        req_valid = 4'b0001;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk);
            req_valid = 4'h0;
            #1;
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                rd = rsp_data;
                id = rsp_id;
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL wrrd_timeout: got no rsp_valid want one within 12 cycles"); end
        checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL wrrd_data: got %h want 5a", rd); end
        checks++; if (id !== 2'd0) begin errors++; $display("FAIL wrrd_id: got %0d want 0", id); end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0; req_wr = '0; req_sel = '0; req_data = '0;
        use_ovr = 1'b0; din_ovr = '0;
        v3 = '0; wr3 = '0; sel3 = '0; data3 = '0; din3 = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_contention();
        test_drop();
        test_reset_mid();
        test_oor();
        test_wr_rd();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
